// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C states, bit-level constants and default address
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } i2c_state_e;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h3C;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SCL/SDA synchronizer with SCL edge and START/STOP detect
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_dly_q;
  logic                   sda_dly_q;
  logic                   scl_s;

  // Synchronizer chains plus one delay flop; idle bus level is high so reset to 1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_sync_q[SYNC_STAGES-1];
      sda_dly_q  <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_o      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_o = scl_s & ~scl_dly_q;
  assign scl_fall_o = ~scl_s & scl_dly_q;
  // SDA may only move while SCL is steadily high for a bus condition
  assign start_o    = scl_s & scl_dly_q & sda_dly_q & ~sda_o;
  assign stop_o     = scl_s & scl_dly_q & ~sda_dly_q & sda_o;

endmodule

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target with write return path and one-byte read holding register (optional clock stretch: I2C_SLAVE_STRETCH_EN)
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] data_slave_read,
  output logic       data_slave_read_valid,
  input  logic [7:0] data_slave_write,
  input  logic       data_slave_write_valid,
  output logic       data_slave_write_req,
  output logic       busy,
  output logic       tx_underrun
);

  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;

  i2c_state_e state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [7:0] shift_d;
  logic [7:0] hold_q;
  logic       hold_full_q;
  logic       sda_oe_q;
  logic       scl_oe_q;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;
  logic       wr_req_q;
  logic       busy_q;
  logic       underrun_q;

  i2c_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .clk_i      (pclk),
    .rst_i      (preset),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  // Byte being assembled including the bit sampled on this SCL rise
  assign shift_d = {shift_q[6:0], sda_s};

  // Protocol FSM, holding register and all registered outputs
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      wr_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_req_q   <= 1'b0;
      // Last write wins; a consume in RD_LOAD below only empties if no new load
      if (data_slave_write_valid) begin
        hold_q      <= data_slave_write;
        hold_full_q <= 1'b1;
      end
      if (start_det) begin
        state_q    <= ST_ADDR;
        bit_cnt_q  <= 3'd0;
        sda_oe_q   <= 1'b0;
        scl_oe_q   <= 1'b0;
        underrun_q <= 1'b0;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        scl_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_WAIT_STOP: begin
          end
          ST_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == ST_WR_DATA) begin
                  rd_data_q  <= shift_d;
                  rd_valid_q <= 1'b1;
                  state_q    <= ST_WR_ACK;
                end else if (shift_d[7:1] == SLAVE_ADDR) begin
                  busy_q  <= 1'b1;
                  state_q <= ST_ADDR_ACK;
                end else begin
                  state_q <= ST_WAIT_STOP;
                end
              end
            end
          end
          // First fall (end of bit 8) drives ACK; second fall ends the ACK clock
          ST_ADDR_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 3'd0;
                if (state_q == ST_ADDR_ACK && shift_q[0] == I2C_RW_READ) begin
                  state_q <= ST_RD_LOAD;
                end else begin
                  state_q <= ST_WR_DATA;
                end
              end
            end
          end
          ST_RD_LOAD: begin
            if (hold_full_q) begin
              shift_q   <= hold_q;
              sda_oe_q  <= ~hold_q[7];
              wr_req_q  <= 1'b1;
              scl_oe_q  <= 1'b0;
              bit_cnt_q <= 3'd0;
              state_q   <= ST_RD_DATA;
              if (!data_slave_write_valid) begin
                hold_full_q <= 1'b0;
              end
            end else begin
`ifdef I2C_SLAVE_STRETCH_EN
              scl_oe_q <= 1'b1;
`else
              underrun_q <= 1'b1;
              shift_q    <= 8'hFF;
              sda_oe_q   <= 1'b0;
              bit_cnt_q  <= 3'd0;
              state_q    <= ST_RD_DATA;
`endif
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                state_q  <= ST_RD_ACK;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b1};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && sda_s == I2C_NACK) begin
              state_q <= ST_WAIT_STOP;
            end else if (scl_fall) begin
              state_q <= ST_RD_LOAD;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign scl_oe                = scl_oe_q;
  assign sda_oe                = sda_oe_q;
  assign data_slave_read       = rd_data_q;
  assign data_slave_read_valid = rd_valid_q;
  assign data_slave_write_req  = wr_req_q;
  assign busy                  = busy_q;
  assign tx_underrun           = underrun_q;

endmodule

// File: doc/i2c_slave_responder.md
Name: i2c_slave_responder

Overview:
- I2C target (slave) RTL for the far end of the I2C master link: decodes START/STOP and address, acknowledges its own address, and returns received write bytes to the user side.
- Serves master read transfers from a one-byte transmit holding register.
- Runs fully on pclk with oversampled SCL/SDA. Open-drain pads are driven through pull-low enables.

Parameters:
- SLAVE_ADDR, 7'h3C, 7-bit address this target acknowledges.
- SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (minimum 2).

Ports:
- pclk  input  1  system clock. Interface is one clock; reset is asynchronous and active-high.
- preset  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL pad level.
- sda_i  input  1  SDA pad level.
- scl_oe  output  1  1 = pull SCL low (clock stretch only).
- sda_oe  output  1  1 = pull SDA low.
- data_slave_read  output  8  last byte written by master.
- data_slave_read_valid  output  1  one-pclk pulse when data_slave_read updates.
- data_slave_write  input  8  byte to return on master read.
- data_slave_write_valid  input  1  load data_slave_write into holding register.
- data_slave_write_req  output  1  one-pclk pulse when holding register is consumed.
- busy  output  1  high from address match until STOP.
- tx_underrun  output  1  sticky; set when a read byte was needed and holding register was empty. Cleared by preset or START.

Behaviour:
- Reset: all outputs 0 (scl_oe and sda_oe released), data_slave_read = 8'h00, holding register empty, state IDLE.
- Reset mid-transfer releases both lines immediately (async).
- Sampling: scl_i/sda_i pass through SYNC_STAGES flops, then one delay flop for edge detect. pclk must be ≥ 8× SCL.
- START = synced SDA fall while SCL high. STOP = synced SDA rise while SCL high. Both are detected in every state, with priority over bit handling.
  - START always goes to ADDR, with bit counter cleared.
  - STOP always goes to IDLE and releases sda_oe.
- Data sampled on SCL rise, MSB first. sda_oe changes only on the pclk after a detected SCL fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W). On the 8th rise, a match goes to ADDR_ACK; a mismatch goes to WAIT_STOP (never drives).
  - ADDR_ACK: sda_oe = 1 for the ACK clock; busy = 1. On the ACK's SCL fall: write goes to WR_DATA; read goes to RD_LOAD.
  - WR_DATA: shift 8 bits. On the 8th rise, latch data_slave_read and pulse data_slave_read_valid (one pclk), then go to WR_ACK.
  - WR_ACK: drive ACK. On SCL fall, go to WR_DATA.
  - RD_LOAD: same pclk as entry.
    - Holding register full: move it to the shift register, pulse data_slave_write_req, mark empty, go to RD_DATA.
    - Empty: set tx_underrun, shift 8'hFF, go to RD_DATA.
  - RD_DATA: sda_oe = ~shift[7], updated after each SCL fall. After the 8th bit's fall, release SDA and go to RD_ACK.
  - RD_ACK: sample master ACK on SCL rise. Low (ACK): on fall, go to RD_LOAD. High (NACK): go to WAIT_STOP.
  - WAIT_STOP: lines released until STOP/START.
- Holding register: data_slave_write_valid while full overwrites it (last write wins). A load and a consume in the same pclk: the consume takes the old byte, and the new byte stays held (full).
- Repeated START after a write, with a read address, is supported.
- data_slave_read holds its value until the next completed byte.

Optional Feature:
- Macro: I2C_SLAVE_STRETCH_EN.
- Defined:
  - In RD_LOAD with the holding register empty, assert scl_oe (hold SCL low) and stay in RD_LOAD.
  - On data_slave_write_valid, load it, release scl_oe the next pclk, and continue.
  - tx_underrun is never set.
  - STOP/START aborts the stretch.
- Undefined: scl_oe is tied 0; underrun sends 8'hFF as above.

Decomposition:
- Shared package i2c_pkg:
  - State enum typedef for the states above.
  - Constants I2C_ACK = 1'b0, I2C_NACK = 1'b1, I2C_RW_READ = 1'b1.
  - Default address constant.
- Natural sub-module: i2c_line_sync (synchronizer plus SCL rise/fall and START/STOP detect), reusable by the master.

Test Plan:
- Write to 0x3C (byte 8'h78) with data 8'hA5, 8'h5A, then STOP → ACK on all three bytes. data_slave_read_valid pulses twice, with values A5 then 5A. busy drops after STOP.
- Write to 0x3D → no ACK (SDA high in 9th clock), sda_oe never asserted, no valid pulse, busy = 0.
- Preload 8'hC3, read from 0x3C (byte 8'h79), master NACK → SDA bits 1100_0011, one data_slave_write_req pulse, state returns to WAIT_STOP then IDLE on STOP.
- Read two bytes with master ACK then NACK, second byte not loaded → second byte is 8'hFF and tx_underrun = 1. With I2C_SLAVE_STRETCH_EN, SCL is held low until data_slave_write_valid supplies 8'h3E, then 8'h3E is sent.
- Write 8'h11, repeated START, then read → ACK on readdress, read phase entered without STOP, busy stays 1 throughout.
- Assert preset during RD_DATA with sda_oe = 1 → sda_oe/scl_oe drop to 0 immediately; a following transfer to 0x3C works normally.
